// File: rtl/map_pkg.sv
// Shared types and default region tables for the map region scanner.
// Table boxes are stored pre-offset, so the scanner only does plain inclusive compares.
package map_pkg;

  localparam int MAP_CW = 11;

  typedef struct packed {
    logic [MAP_CW-1:0]   hstart;
    logic [MAP_CW-1:0]   hstop;
    logic [MAP_CW-1:0]   vstart;
    logic [MAP_CW-1:0]   vstop;
    logic [2*MAP_CW-1:0] attr;
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAD    = 3'd1,
    ST_PLAT   = 3'd2,
    ST_EDGE   = 3'd3,
    ST_COMMIT = 3'd4
  } scan_state_t;

  function automatic region_t mk_region(input logic [MAP_CW-1:0] hs, input logic [MAP_CW-1:0] he,
                                        input logic [MAP_CW-1:0] vs, input logic [MAP_CW-1:0] ve,
                                        input logic [2*MAP_CW-1:0] attr);
    region_t r;
    r.hstart = hs;
    r.hstop  = he;
    r.vstart = vs;
    r.vstop  = ve;
    r.attr   = attr;
    return r;
  endfunction

  // Entry 0 is the rightmost element of each concatenation; attr = {limit_min, limit_max}
  localparam region_t [4:0] LADDER_DEF = {
    mk_region(11'd900, 11'd940, 11'd600, 11'd900, {11'd580, 11'd880}),
    mk_region(11'd290, 11'd330, 11'd180, 11'd420, {11'd160, 11'd400}),
    mk_region(11'd500, 11'd540, 11'd100, 11'd300, {11'd80,  11'd280}),
    mk_region(11'd280, 11'd320, 11'd150, 11'd260, {11'd130, 11'd240}),
    mk_region(11'd100, 11'd140, 11'd400, 11'd560, {11'd380, 11'd520})
  };

  localparam region_t [3:0] PLAT_DEF = {
    mk_region(11'd0,   11'd2047, 11'd900, 11'd1000, {20'd0, 2'b01}),
    mk_region(11'd840, 11'd1200, 11'd560, 11'd700,  {20'd0, 2'b11}),
    mk_region(11'd0,   11'd1000, 11'd100, 11'd199,  {20'd0, 2'b01}),
    mk_region(11'd0,   11'd832,  11'd417, 11'd559,  {20'd0, 2'b10})
  };

  localparam region_t [3:0] EDGE_DEF = {
    mk_region(11'd1500, 11'd1600, 11'd1500, 11'd1600, {11'd0, 11'd1700}),
    mk_region(11'd0,    11'd20,   11'd0,    11'd50,   {11'd0, 11'd50}),
    mk_region(11'd1000, 11'd1040, 11'd500,  11'd600,  {11'd0, 11'd700}),
    mk_region(11'd580,  11'd620,  11'd300,  11'd400,  {11'd0, 11'd600})
  };

endpackage

// File: rtl/map_region_scanner_region_hit.sv
// Inclusive unsigned point-in-box test, shared by every scan category.
module region_hit
  import map_pkg::*;
(
  input  region_t           box,
  input  logic [MAP_CW-1:0] x,
  input  logic [MAP_CW-1:0] y,
  output logic              hit
);

  assign hit = (x >= box.hstart) && (x <= box.hstop) &&
               (y >= box.vstart) && (y <= box.vstop);

endmodule

// File: rtl/map_region_scanner.sv
// Sequential table scanner: one region compared per clock across ladder, platform and
// edge tables, with all results committed together alongside a one-cycle valid pulse.
module map_region_scanner
  import map_pkg::*;
#(
  parameter int N_LADDER = 5,
  parameter int N_PLAT   = 4,
  parameter int N_EDGE   = 4,
  parameter int CW       = MAP_CW,
  parameter region_t [((N_LADDER > 0) ? N_LADDER : 1)-1:0] LADDER_TBL = LADDER_DEF,
  parameter region_t [((N_PLAT   > 0) ? N_PLAT   : 1)-1:0] PLAT_TBL   = PLAT_DEF,
  parameter region_t [((N_EDGE   > 0) ? N_EDGE   : 1)-1:0] EDGE_TBL   = EDGE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [CW-1:0] xpos,
  input  logic [CW-1:0] ypos,
  output logic          busy,
  output logic          req_drop,
  output logic          valid,
  output logic          ladder,
  output logic [((N_LADDER > 0) ? $clog2(N_LADDER + 1) : 1)-1:0] ladder_id,
  output logic [CW-1:0] limit_ypos_min,
  output logic [CW-1:0] limit_ypos_max,
  output logic [1:0]    platform,
  output logic          end_of_platform,
  output logic [CW-1:0] landing_ypos
);

  localparam int LIDW  = (N_LADDER > 0) ? $clog2(N_LADDER + 1) : 1;
  localparam int NMAX0 = (N_LADDER > N_PLAT) ? N_LADDER : N_PLAT;
  localparam int NMAX  = (NMAX0 > N_EDGE) ? NMAX0 : N_EDGE;
  localparam int IW    = (NMAX > 1) ? $clog2(NMAX + 1) : 1;

  scan_state_t   state_r, state_nxt_s;
  logic [IW-1:0] idx_r, idx_nxt_s;
  logic [CW-1:0] x_r, y_r;
  region_t       box_s;
  logic          hit_s, accept_s;

  logic            lad_hit_r, plat_hit_r, edge_hit_r;
  logic [LIDW-1:0] lad_id_r;
  logic [CW-1:0]   lad_min_r, lad_max_r, land_r;
  logic [1:0]      plat_code_r;

  // Empty categories are skipped in the same cycle, so no dead cycles appear
  function automatic scan_state_t first_active(input scan_state_t s);
    scan_state_t r;
    r = ST_COMMIT;
    case (s)
      ST_LAD:  r = (N_LADDER > 0) ? ST_LAD  : ((N_PLAT > 0) ? ST_PLAT : ((N_EDGE > 0) ? ST_EDGE : ST_COMMIT));
      ST_PLAT: r = (N_PLAT   > 0) ? ST_PLAT : ((N_EDGE > 0) ? ST_EDGE : ST_COMMIT);
      ST_EDGE: r = (N_EDGE   > 0) ? ST_EDGE : ST_COMMIT;
      default: r = ST_COMMIT;
    endcase
    return r;
  endfunction

  assign accept_s = (state_r == ST_IDLE) && req;

  // Next-state, index advance and table entry selection
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    box_s       = '0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_nxt_s = first_active(ST_LAD);
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAD: begin
        for (int i = 0; i < N_LADDER; i++) box_s = (idx_r == IW'(i)) ? LADDER_TBL[i] : box_s;
        if (idx_r == IW'(N_LADDER - 1)) begin
          state_nxt_s = first_active(ST_PLAT);
          idx_nxt_s   = '0;
        end else begin
          idx_nxt_s = idx_r + IW'(1);
        end
      end
      ST_PLAT: begin
        for (int i = 0; i < N_PLAT; i++) box_s = (idx_r == IW'(i)) ? PLAT_TBL[i] : box_s;
        if (idx_r == IW'(N_PLAT - 1)) begin
          state_nxt_s = first_active(ST_EDGE);
          idx_nxt_s   = '0;
        end else begin
          idx_nxt_s = idx_r + IW'(1);
        end
      end
      ST_EDGE: begin
        for (int i = 0; i < N_EDGE; i++) box_s = (idx_r == IW'(i)) ? EDGE_TBL[i] : box_s;
        if (idx_r == IW'(N_EDGE - 1)) begin
          state_nxt_s = ST_COMMIT;
          idx_nxt_s   = '0;
        end else begin
          idx_nxt_s = idx_r + IW'(1);
        end
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  region_hit u_hit (.box(box_s), .x(x_r), .y(y_r), .hit(hit_s));

  // State, index, status flags and the position latched at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      x_r      <= '0;
      y_r      <= '0;
      busy     <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      idx_r    <= idx_nxt_s;
      busy     <= (state_nxt_s != ST_IDLE);
      req_drop <= req && (state_r != ST_IDLE);
      if (accept_s) begin
        x_r <= xpos;
        y_r <= ypos;
      end
    end
  end

  // Scratch results: only the first hit of each category is kept
  always_ff @(posedge clk) begin
    if (rst || accept_s) begin
      lad_hit_r   <= 1'b0;
      lad_id_r    <= '0;
      lad_min_r   <= '0;
      lad_max_r   <= '0;
      plat_hit_r  <= 1'b0;
      plat_code_r <= 2'b00;
      edge_hit_r  <= 1'b0;
      land_r      <= '0;
    end else begin
      if ((state_r == ST_LAD) && hit_s && !lad_hit_r) begin
        lad_hit_r <= 1'b1;
        lad_id_r  <= LIDW'(idx_r);
        lad_min_r <= box_s.attr[2*CW-1:CW];
        lad_max_r <= box_s.attr[CW-1:0];
      end
      if ((state_r == ST_PLAT) && hit_s && !plat_hit_r) begin
        plat_hit_r  <= 1'b1;
        plat_code_r <= box_s.attr[1:0];
      end
      if ((state_r == ST_EDGE) && hit_s && !edge_hit_r) begin
        edge_hit_r <= 1'b1;
        land_r     <= box_s.attr[CW-1:0];
      end
    end
  end

  // Result registers update together in COMMIT; limits and landing hold on a miss
  always_ff @(posedge clk) begin
    if (rst) begin
      valid           <= 1'b0;
      ladder          <= 1'b0;
      ladder_id       <= LIDW'(N_LADDER);
      limit_ypos_min  <= '0;
      limit_ypos_max  <= '0;
      platform        <= 2'b00;
      end_of_platform <= 1'b0;
      landing_ypos    <= '0;
    end else begin
      valid <= (state_r == ST_COMMIT);
      if (state_r == ST_COMMIT) begin
        ladder          <= lad_hit_r;
        ladder_id       <= lad_hit_r ? lad_id_r : LIDW'(N_LADDER);
        platform        <= plat_hit_r ? plat_code_r : 2'b00;
        end_of_platform <= edge_hit_r;
        if (lad_hit_r) begin
          limit_ypos_min <= lad_min_r;
          limit_ypos_max <= lad_max_r;
        end
        if (edge_hit_r) begin
          landing_ypos <= land_r;
        end
      end
    end
  end

endmodule
